load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one core access at a time, drives the data memory
// for a single ACCESS cycle, then holds the extended response until consumed.
module load_store_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    output logic [3:0]  mem_strobe,
    input  logic [31:0] mem_rd
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state;
    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;

    logic        err;
    logic [3:0]  strobe;
    logic [31:0] wd;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    // Legality check on the captured request: illegal size or misalignment
    always_comb begin
        err = 1'b0;
        case (size_q)
            2'b00:   err = 1'b0;
            2'b01:   err = addr_q[0];
            2'b10:   err = (addr_q[1:0] != 2'b00);
            default: err = 1'b1;
        endcase
    end

    // Store lane strobes and lane-replicated write data
    always_comb begin
        strobe = 4'b0000;
        wd     = wdata_q;
        case (size_q)
            2'b00: begin
                strobe = 4'b0001 << addr_q[1:0];
                wd     = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                strobe = addr_q[1] ? 4'b1100 : 4'b0011;
                wd     = {2{wdata_q[15:0]}};
            end
            2'b10: begin
                strobe = 4'b1111;
                wd     = wdata_q;
            end
            default: strobe = 4'b0000;
        endcase
        if (!we_q || err) begin
            strobe = 4'b0000;
        end
    end

    // Load lane selection and sign/zero extension; stores and errors return zero
    always_comb begin
        ld_data = 32'h0000_0000;
        case (addr_q[1:0])
            2'b00:   ld_byte = mem_rd[7:0];
            2'b01:   ld_byte = mem_rd[15:8];
            2'b10:   ld_byte = mem_rd[23:16];
            default: ld_byte = mem_rd[31:24];
        endcase
        ld_half = addr_q[1] ? mem_rd[31:16] : mem_rd[15:0];
        if (!we_q && !err) begin
            case (size_q)
                2'b00:   ld_data = uns_q ? {24'h000000, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
                2'b01:   ld_data = uns_q ? {16'h0000, ld_half} : {{16{ld_half[15]}}, ld_half};
                default: ld_data = mem_rd;
            endcase
        end
    end

    // Request capture, load data sampling and IDLE/ACCESS/RESP sequencing
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= 32'h0000_0000;
            wdata_q <= 32'h0000_0000;
            rdata_q <= 32'h0000_0000;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        size_q  <= req_size;
                        uns_q   <= req_unsigned;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    rdata_q <= ld_data;
                    state   <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready  = (state == IDLE) && !reset;
    assign resp_valid = (state == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = (state == RESP) && err;
    assign mem_we     = (state == ACCESS) && we_q && !err;
    assign mem_addr   = addr_q;
    assign mem_wd     = wd;
    assign mem_strobe = strobe;

endmodule
